// File: rtl/game369_pkg.sv
// Shared types, clap digit constants and elaboration-time BCD conversion for the 369 game counter.
package game369_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] CLAP_DIGIT_3 = 4'd3;
  localparam logic [3:0] CLAP_DIGIT_6 = 4'd6;
  localparam logic [3:0] CLAP_DIGIT_9 = 4'd9;

  // Converts a non-negative decimal integer into up to four packed BCD digits.
  function automatic logic [15:0] to_bcd(int value);
    logic [15:0] result;
    int          rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < 4; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/game369_counter_bcd_digit.sv
// One decimal digit of the 369 counter: loadable, wraps 9 -> 0 with carry, flags 3/6/9.
module bcd_digit
  import game369_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       is_clap
);

  logic [3:0] digit_q, digit_d;

  // Load takes priority so a round restart never mixes with a pending carry.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (inc) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q         = digit_q;
  assign carry_out = inc & (digit_q == 4'd9);
  assign is_clap   = (digit_q == CLAP_DIGIT_3) | (digit_q == CLAP_DIGIT_6) |
                     (digit_q == CLAP_DIGIT_9);

endmodule

// File: rtl/game369_counter.sv
// N-digit BCD 369-game counter with IDLE/RUN/DONE run control and clap decode.
// Optional macro GAME369_MOD3_EN adds clap_mod3 (value divisible by 3) via a residue register.
module game369_counter
  import game369_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MAX_VAL   = 99,
  parameter int START_VAL = 1,
  parameter int WRAP      = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           step,
  input  logic                           pause,
  output logic [4*DIGITS-1:0]            count_bcd,
  output logic                           clap,
  output logic [$clog2(DIGITS+1)-1:0]    clap_cnt,
  output logic                           wrap,
  output logic                           busy
`ifdef GAME369_MOD3_EN
  ,
  output logic                           clap_mod3
`endif
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [15:0] START_FULL = to_bcd(START_VAL);
  localparam logic [15:0] MAX_FULL   = to_bcd(MAX_VAL);
  localparam logic [4*DIGITS-1:0] START_BCD = START_FULL[4*DIGITS-1:0];
  localparam logic [4*DIGITS-1:0] MAX_BCD   = MAX_FULL[4*DIGITS-1:0];

  if (DIGITS < 1 || DIGITS > 4 || MAX_VAL >= 10**DIGITS || START_VAL > MAX_VAL ||
      START_VAL < 0) begin : g_bad_params
    $error("game369_counter: illegal DIGITS/MAX_VAL/START_VAL combination");
  end

  state_t state_q, state_d;
  logic   wrap_q, wrap_d;
  logic   loadEn, incEn, accept, atMax;
  logic   topCarry;
  logic [DIGITS-1:0] clapVec;

  assign accept = (state_q == RUN) & step & ~pause;
  assign atMax  = (count_bcd == MAX_BCD);

  // Start is only honoured outside RUN; in RUN an accepted step either increments or ends the round.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    loadEn  = 1'b0;
    incEn   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          loadEn  = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (!atMax) begin
            incEn = 1'b1;
          end else if (WRAP != 0) begin
            loadEn = 1'b1;
            wrap_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic digInc, digCarry;
    if (i == 0) begin : g_lsd
      assign digInc = incEn;
    end else begin : g_upper
      assign digInc = g_digit[i-1].digCarry;
    end
    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .inc      (digInc),
      .load     (loadEn),
      .load_val (START_BCD[4*i +: 4]),
      .q        (count_bcd[4*i +: 4]),
      .carry_out(digCarry),
      .is_clap  (clapVec[i])
    );
  end

  // The MAX_VAL compare stops increments before the top digit could ever carry out.
  assign topCarry = g_digit[DIGITS-1].digCarry;
  assert property (@(posedge clk) disable iff (reset) !topCarry);

  always_comb begin
    clap_cnt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clap_cnt = clap_cnt + CW'(clapVec[i]);
    end
  end

  assign wrap = wrap_q;
  assign busy = (state_q == RUN);

`ifdef GAME369_MOD3_EN
  localparam logic [1:0] START_RES = 2'(START_VAL % 3);
  logic [1:0] res_q, res_d;

  // Residue tracks value mod 3 alongside the digits, so no divider is needed.
  always_comb begin
    res_d = res_q;
    if (loadEn) begin
      res_d = START_RES;
    end else if (incEn) begin
      res_d = (res_q == 2'd2) ? 2'd0 : res_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= 2'd0;
    end else begin
      res_q <= res_d;
    end
  end

  assign clap_mod3 = (state_q != IDLE) && (res_q == 2'd0);
  assign clap      = (|clapVec) | clap_mod3;
`else
  assign clap = |clapVec;
`endif

endmodule

// File: tb/tb_game369_counter.sv
// Self-checking bench: two counters (WRAP=1 and WRAP=0) share stimulus and are compared to a decimal model.
// Honours GAME369_MOD3_EN when defined.
module tb_game369_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       pause = 1'b0;
  logic       checkEn = 1'b0;

  logic [7:0] cnt0, cnt1;
  logic [1:0] cc0, cc1;
  logic       clap0, clap1, wrap0, wrap1, busy0, busy1;
  logic       m3_0, m3_1;

  int nChecks = 0;
  int nErrors = 0;

  // Model state per instance: 0 = idle, 1 = run, 2 = done
  int mSt[2]   = '{0, 0};
  int mVal[2]  = '{0, 0};
  int mWrap[2] = '{0, 0};
  int wrapParam[2] = '{1, 0};

  localparam int START = 1;
  localparam int MAXV  = 99;

  always #5 clk = ~clk;

  game369_counter #(.DIGITS(2), .MAX_VAL(99), .START_VAL(1), .WRAP(1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .step(step), .pause(pause),
    .count_bcd(cnt0), .clap(clap0), .clap_cnt(cc0), .wrap(wrap0), .busy(busy0)
`ifdef GAME369_MOD3_EN
    , .clap_mod3(m3_0)
`endif
  );

  game369_counter #(.DIGITS(2), .MAX_VAL(99), .START_VAL(1), .WRAP(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .step(step), .pause(pause),
    .count_bcd(cnt1), .clap(clap1), .clap_cnt(cc1), .wrap(wrap1), .busy(busy1)
`ifdef GAME369_MOD3_EN
    , .clap_mod3(m3_1)
`endif
  );

`ifndef GAME369_MOD3_EN
  assign m3_0 = 1'b0;
  assign m3_1 = 1'b0;
`endif

  function automatic logic [7:0] expBcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clapDigits(int v);
    int n = 0;
    int d;
    for (int i = 0; i < 2; i++) begin
      d = v % 10;
      if (d == 3 || d == 6 || d == 9) n++;
      v = v / 10;
    end
    return n;
  endfunction

  function automatic logic expMod3(int st, int v);
`ifdef GAME369_MOD3_EN
    return (st != 0) && (v % 3 == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareInst(input int k, input logic [7:0] c, input logic b, input logic cl,
                             input logic [1:0] cc, input logic w, input logic m3);
    checkOutput($sformatf("count%0d", k), 32'(c), 32'(expBcd(mVal[k])));
    checkOutput($sformatf("busy%0d", k), 32'(b), 32'(mSt[k] == 1));
    checkOutput($sformatf("clap_cnt%0d", k), 32'(cc), 32'(clapDigits(mVal[k])));
    checkOutput($sformatf("clap%0d", k), 32'(cl),
                32'((clapDigits(mVal[k]) > 0) || expMod3(mSt[k], mVal[k])));
    checkOutput($sformatf("wrap%0d", k), 32'(w), 32'(mWrap[k]));
`ifdef GAME369_MOD3_EN
    checkOutput($sformatf("clap_mod3_%0d", k), 32'(m3), 32'(expMod3(mSt[k], mVal[k])));
`else
    if (m3 !== 1'b0) checkOutput("mod3_tie", 32'(m3), 32'd0);
`endif
  endtask

  // Decimal reference model of the game rules, advanced on the same edges as the DUTs.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mSt[k]   <= 0;
        mVal[k]  <= 0;
        mWrap[k] <= 0;
      end else begin
        mWrap[k] <= 0;
        if (mSt[k] != 1) begin
          if (start) begin
            mSt[k]  <= 1;
            mVal[k] <= START;
          end
        end else if (step && !pause) begin
          if (mVal[k] == MAXV) begin
            if (wrapParam[k] != 0) begin
              mVal[k]  <= START;
              mWrap[k] <= 1;
            end else begin
              mSt[k] <= 2;
            end
          end else begin
            mVal[k] <= mVal[k] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      compareInst(0, cnt0, busy0, clap0, cc0, wrap0, m3_0);
      compareInst(1, cnt1, busy1, clap1, cc1, wrap1, m3_1);
    end
  end

  // One clock of stimulus; outputs are settled when it returns.
  task automatic applyStimulus(input logic s, input logic t, input logic p);
    @(negedge clk);
    start = s;
    step  = t;
    pause = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    step  = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    checkEn = 1'b1;
    #1;
    checkOutput("reset_count", 32'(cnt0), 32'h0);
    checkOutput("reset_busy", 32'(busy0), 32'h0);
    checkOutput("reset_clap", 32'(clap0), 32'h0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;

    applyStimulus(1, 0, 0);
    checkOutput("start_count", 32'(cnt0), 32'h01);
    checkOutput("start_busy", 32'(busy0), 32'h1);
    checkOutput("start_clap", 32'(clap0), 32'h0);

    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0);
    checkOutput("at13_count", 32'(cnt0), 32'h13);
    checkOutput("at13_clap", 32'(clap0), 32'h1);
    checkOutput("at13_clapcnt", 32'(cc0), 32'h1);

    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1);
    checkOutput("pause_count", 32'(cnt0), 32'h13);
    checkOutput("pause_wrap", 32'(wrap0), 32'h0);

    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0);
    checkOutput("at30_clapcnt", 32'(cc0), 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
    checkOutput("at33_clapcnt", 32'(cc0), 32'h2);
    for (int i = 0; i < 66; i++) applyStimulus(0, 1, 0);
    checkOutput("at99_count", 32'(cnt1), 32'h99);
    checkOutput("at99_clapcnt", 32'(cc1), 32'h2);

    applyStimulus(0, 1, 0);
    checkOutput("wrap_count", 32'(cnt0), 32'h01);
    checkOutput("wrap_pulse", 32'(wrap0), 32'h1);
    checkOutput("stop_count", 32'(cnt1), 32'h99);
    checkOutput("stop_busy", 32'(busy1), 32'h0);
    applyStimulus(0, 0, 0);
    checkOutput("wrap_drop", 32'(wrap0), 32'h0);

    applyStimulus(1, 1, 0);
    checkOutput("done_restart", 32'(cnt1), 32'h01);
    checkOutput("run_start_ignored", 32'(cnt0), 32'h02);

    for (int i = 0; i < 45; i++) applyStimulus(0, 1, 0);
    checkOutput("at47_count", 32'(cnt0), 32'h47);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_count", 32'(cnt0), 32'h0);
    checkOutput("async_busy", 32'(busy0), 32'h0);
    @(negedge clk) reset = 1'b0;
    applyStimulus(0, 1, 0);
    checkOutput("idle_after_reset", 32'(busy0), 32'h0);
    applyStimulus(1, 0, 0);
    checkOutput("restart_count", 32'(cnt0), 32'h01);

    @(negedge clk);
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
